// File: rtl/counter_updown_lim_pkg.sv
// Shared types for the limited up/down counter: operation encoding and width bound.
// Optional sticky-error feature is selected with COUNTER_UPDOWN_STICKY_EN.
package counter_pkg;

  localparam int MAX_WIDTH = 16;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_CLR  = 3'd1,
    OP_LOAD = 3'd2,
    OP_INC  = 3'd3,
    OP_DEC  = 3'd4
  } op_t;

  // Resolve one clock edge's controls into a single operation, highest priority first.
  function automatic op_t decode_op(
    input logic clr,
    input logic parallel,
    input logic en,
    input logic increase,
    input logic decrease
  );
    op_t op;
    op = OP_HOLD;
    if (clr) begin
      op = OP_CLR;
    end else if (parallel) begin
      op = OP_LOAD;
    end else if (en && increase && !decrease) begin
      op = OP_INC;
    end else if (en && decrease && !increase) begin
      op = OP_DEC;
    end
    return op;
  endfunction

endpackage

// File: rtl/counter_updown_lim_if.sv
// Control/status bundle of the limited up/down counter; master drives controls, slave is the counter.
// COUNTER_UPDOWN_STICKY_EN adds err_clr / err_sticky.
interface counter_updown_lim_if #(
  parameter int WIDTH = 6
);
  import counter_pkg::*;

  logic             clr;
  logic             en;
  logic             increase;
  logic             decrease;
  logic             parallel;
  logic [WIDTH-1:0] load;
  logic [WIDTH-1:0] limit;
  logic             wrap;
  logic [WIDTH-1:0] Q_OUT;
  logic             at_max;
  logic             at_min;
  logic             ovf;
  logic             unf;
  // Operation the counter decoded for the coming edge; lets checkers see the priority decode.
  op_t              dbg_op;
`ifdef COUNTER_UPDOWN_STICKY_EN
  logic             err_clr;
  logic             err_sticky;
`endif

  modport master (
    output clr, en, increase, decrease, parallel, load, limit, wrap,
`ifdef COUNTER_UPDOWN_STICKY_EN
    output err_clr,
    input  err_sticky,
`endif
    input  Q_OUT, at_max, at_min, ovf, unf, dbg_op
  );

  modport slave (
    input  clr, en, increase, decrease, parallel, load, limit, wrap,
`ifdef COUNTER_UPDOWN_STICKY_EN
    input  err_clr,
    output err_sticky,
`endif
    output Q_OUT, at_max, at_min, ovf, unf, dbg_op
  );

endinterface

// File: rtl/counter_updown_lim_next_val.sv
// Combinational next-count calculation for one decoded operation, with wrap/saturation events.
// COUNTER_UPDOWN_STICKY_EN adds the o_sat saturation/clamp event output.
module counter_next_val
  import counter_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_limit,
  input  op_t              i_op,
  input  logic             i_wrap,
  input  logic [WIDTH-1:0] i_load,
  output logic [WIDTH-1:0] o_next_q,
  output logic             o_ovf,
  output logic             o_unf
`ifdef COUNTER_UPDOWN_STICKY_EN
  ,
  output logic             o_sat
`endif
);

  // One guard bit so neither +1 nor -1 can silently wrap modulo 2^WIDTH.
  logic [WIDTH:0] w_q_ext;
  logic [WIDTH:0] w_lim_ext;
  logic [WIDTH:0] w_load_ext;
  logic [WIDTH:0] w_q_plus;
  logic [WIDTH:0] w_q_minus;
  logic           w_below_lim;
  logic           w_above_lim;
  logic           w_is_zero;
  logic           w_load_clamp;

  assign w_q_ext      = {1'b0, i_q};
  assign w_lim_ext    = {1'b0, i_limit};
  assign w_load_ext   = {1'b0, i_load};
  assign w_q_plus     = w_q_ext + {{WIDTH{1'b0}}, 1'b1};
  assign w_q_minus    = w_q_ext - {{WIDTH{1'b0}}, 1'b1};
  assign w_below_lim  = (w_q_plus <= w_lim_ext);
  assign w_above_lim  = (w_q_ext > w_lim_ext);
  assign w_is_zero    = w_q_minus[WIDTH];
  assign w_load_clamp = (w_load_ext > w_lim_ext);

  always_comb begin
    o_next_q = i_q;
    o_ovf    = 1'b0;
    o_unf    = 1'b0;
    unique case (i_op)
      OP_CLR: begin
        o_next_q = '0;
      end
      OP_LOAD: begin
        o_next_q = w_load_clamp ? i_limit : i_load;
      end
      OP_INC: begin
        if (w_below_lim) begin
          o_next_q = w_q_plus[WIDTH-1:0];
        end else if (i_wrap) begin
          o_next_q = '0;
          o_ovf    = 1'b1;
        end else begin
          o_next_q = i_limit;
        end
      end
      OP_DEC: begin
        // A count left above a lowered limit is pulled back to the limit rather than decremented.
        if (w_above_lim) begin
          o_next_q = i_limit;
        end else if (!w_is_zero) begin
          o_next_q = w_q_minus[WIDTH-1:0];
        end else if (i_wrap) begin
          o_next_q = i_limit;
          o_unf    = 1'b1;
        end else begin
          o_next_q = '0;
        end
      end
      default: begin
        o_next_q = i_q;
      end
    endcase
  end

`ifdef COUNTER_UPDOWN_STICKY_EN
  assign o_sat = ((i_op == OP_LOAD) && w_load_clamp)
              || ((i_op == OP_INC) && !i_wrap && !w_below_lim)
              || ((i_op == OP_DEC) && !i_wrap && w_is_zero);
`endif

endmodule

// File: rtl/counter_updown_lim.sv
// Up/down counter bounded to 0..limit with wrap or saturate, terminal flags and wrap pulses.
// COUNTER_UPDOWN_STICKY_EN adds a sticky saturation error flag with its own clear.
module counter_updown_lim
  import counter_pkg::*;
#(
  parameter int WIDTH     = 6,
  parameter int RESET_VAL = 0
) (
  input  logic                  CLK,
  input  logic                  CLR_N,
  counter_updown_lim_if.slave   bus
);

  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] r_q;
  logic             r_ovf;
  logic             r_unf;
  op_t              w_op;
  logic [WIDTH-1:0] w_next_q;
  logic             w_ovf_evt;
  logic             w_unf_evt;
`ifdef COUNTER_UPDOWN_STICKY_EN
  logic             w_sat_evt;
  logic             r_err_sticky;
`endif

  assign w_op = decode_op(bus.clr, bus.parallel, bus.en, bus.increase, bus.decrease);

  counter_next_val #(
    .WIDTH (WIDTH)
  ) u_next_val (
    .i_q      (r_q),
    .i_limit  (bus.limit),
    .i_op     (w_op),
    .i_wrap   (bus.wrap),
    .i_load   (bus.load),
    .o_next_q (w_next_q),
    .o_ovf    (w_ovf_evt),
    .o_unf    (w_unf_evt)
`ifdef COUNTER_UPDOWN_STICKY_EN
    ,
    .o_sat    (w_sat_evt)
`endif
  );

  // Pulses are re-evaluated every edge, so they last exactly one cycle unless wraps repeat.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      r_q   <= RST_Q;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_q   <= w_next_q;
      r_ovf <= w_ovf_evt;
      r_unf <= w_unf_evt;
    end
  end

`ifdef COUNTER_UPDOWN_STICKY_EN
  // A new saturation on the same edge as err_clr keeps the flag set.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      r_err_sticky <= 1'b0;
    end else if (w_sat_evt) begin
      r_err_sticky <= 1'b1;
    end else if (bus.err_clr || bus.clr) begin
      r_err_sticky <= 1'b0;
    end
  end

  assign bus.err_sticky = r_err_sticky;
`endif

  assign bus.Q_OUT  = r_q;
  assign bus.ovf    = r_ovf;
  assign bus.unf    = r_unf;
  assign bus.at_max = (r_q >= bus.limit);
  assign bus.at_min = (r_q == '0);
  assign bus.dbg_op = w_op;

endmodule

// File: tb/tb_counter_updown_lim.sv
// Self-checking bench for counter_updown_lim: directed scenarios plus randomized traffic vs a reference model.
// Build with COUNTER_UPDOWN_STICKY_EN to also cover err_sticky / err_clr.
module tb_counter_updown_lim;

  localparam int W = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int m_q = 0;
  bit m_ovf = 0;
  bit m_unf = 0;
  bit m_err = 0;
  logic [W-1:0] exp_q[$];

  counter_updown_lim_if #(.WIDTH(W)) bus ();

  counter_updown_lim #(
    .WIDTH     (W),
    .RESET_VAL (0)
  ) dut (
    .CLK   (clk),
    .CLR_N (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---------------- model ----------------
  function automatic void model_reset();
    m_q = 0; m_ovf = 0; m_unf = 0; m_err = 0;
  endfunction

  function automatic void model_edge();
    int q, lim, ld, nq;
    bit ov, un, sat;
    q = m_q; lim = int'(bus.limit); ld = int'(bus.load);
    nq = q; ov = 0; un = 0; sat = 0;
    if (bus.clr) begin
      nq = 0;
    end else if (bus.parallel) begin
      if (ld > lim) begin nq = lim; sat = 1; end else nq = ld;
    end else if (bus.en && bus.increase && !bus.decrease) begin
      if (q < lim) nq = q + 1;
      else if (bus.wrap) begin nq = 0; ov = 1; end
      else begin nq = lim; sat = 1; end
    end else if (bus.en && bus.decrease && !bus.increase) begin
      if (q > lim) nq = lim;
      else if (q > 0) nq = q - 1;
      else if (bus.wrap) begin nq = lim; un = 1; end
      else sat = 1;
    end
`ifdef COUNTER_UPDOWN_STICKY_EN
    if (sat) m_err = 1;
    else if (bus.err_clr || bus.clr) m_err = 0;
`else
    if (sat) m_err = 1;
`endif
    m_q = nq; m_ovf = ov; m_unf = un;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    bus.clr = 0; bus.en = 1; bus.increase = 0; bus.decrease = 0;
    bus.parallel = 0; bus.load = '0;
`ifdef COUNTER_UPDOWN_STICKY_EN
    bus.err_clr = 0;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    exp_q.push_back(W'(m_q));
    #1;
  endtask

  task automatic load_val(input int v);
    set_idle(); bus.parallel = 1; bus.load = W'(v);
    tick();
    set_idle();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    set_idle(); bus.limit = 6'd63; bus.wrap = 1;
    model_reset();
    #2;
    n_vec++; if (bus.Q_OUT !== 6'd0) begin n_err++; $display("FAIL reset_q: got %0d want 0", bus.Q_OUT); end
    n_vec++; if (bus.ovf !== 1'b0 || bus.unf !== 1'b0) begin n_err++; $display("FAIL reset_pulses: got ovf=%b unf=%b want 0/0", bus.ovf, bus.unf); end
    n_vec++; if (bus.at_min !== 1'b1) begin n_err++; $display("FAIL reset_at_min: got %b want 1", bus.at_min); end
    @(negedge clk); rst_n = 1;
    load_val(23);
    n_vec++; if (bus.Q_OUT !== 6'd23) begin n_err++; $display("FAIL load23: got %0d want 23", bus.Q_OUT); end
    // asynchronous reset between edges
    #2 rst_n = 0; model_reset();
    #1;
    n_vec++; if (bus.Q_OUT !== 6'd0) begin n_err++; $display("FAIL async_reset_q: got %0d want 0", bus.Q_OUT); end
    n_vec++; if (bus.ovf !== 1'b0 || bus.unf !== 1'b0) begin n_err++; $display("FAIL async_reset_pulses: got ovf=%b unf=%b want 0/0", bus.ovf, bus.unf); end
    #1 rst_n = 1;
    load_val(5);
    bus.clr = 1; bus.increase = 1;
    tick(); set_idle();
    n_vec++; if (bus.Q_OUT !== 6'd0) begin n_err++; $display("FAIL clr_over_inc: got %0d want 0", bus.Q_OUT); end
    n_vec++; if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL clr_no_ovf: got %b want 0", bus.ovf); end
  endtask

  task automatic test_wrap_up();
    bus.limit = 6'd9; bus.wrap = 1;
    load_val(9);
    n_vec++; if (bus.at_max !== 1'b1) begin n_err++; $display("FAIL wrap_up_at_max: got %b want 1", bus.at_max); end
    bus.increase = 1; tick(); set_idle();
    n_vec++; if (bus.Q_OUT !== 6'd0) begin n_err++; $display("FAIL wrap_up_q: got %0d want 0", bus.Q_OUT); end
    n_vec++; if (bus.ovf !== 1'b1) begin n_err++; $display("FAIL wrap_up_ovf: got %b want 1", bus.ovf); end
    tick();
    n_vec++; if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL wrap_up_ovf_once: got %b want 0", bus.ovf); end
    bus.wrap = 0;
    load_val(9);
    bus.increase = 1; tick(); set_idle();
    n_vec++; if (bus.Q_OUT !== 6'd9) begin n_err++; $display("FAIL sat_up_q: got %0d want 9", bus.Q_OUT); end
    n_vec++; if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL sat_up_ovf: got %b want 0", bus.ovf); end
  endtask

  task automatic test_wrap_down();
    bus.limit = 6'd40; bus.wrap = 1;
    set_idle(); bus.clr = 1; tick(); set_idle();
    bus.decrease = 1; tick(); set_idle();
    n_vec++; if (bus.Q_OUT !== 6'd40) begin n_err++; $display("FAIL wrap_dn_q: got %0d want 40", bus.Q_OUT); end
    n_vec++; if (bus.unf !== 1'b1) begin n_err++; $display("FAIL wrap_dn_unf: got %b want 1", bus.unf); end
    tick();
    n_vec++; if (bus.unf !== 1'b0) begin n_err++; $display("FAIL wrap_dn_unf_once: got %b want 0", bus.unf); end
    bus.clr = 1; tick(); set_idle();
    bus.wrap = 0; bus.decrease = 1; tick(); set_idle();
    n_vec++; if (bus.Q_OUT !== 6'd0) begin n_err++; $display("FAIL sat_dn_q: got %0d want 0", bus.Q_OUT); end
    n_vec++; if (bus.at_min !== 1'b1 || bus.unf !== 1'b0) begin n_err++; $display("FAIL sat_dn_flags: got at_min=%b unf=%b want 1/0", bus.at_min, bus.unf); end
  endtask

  task automatic test_load_clamp();
    bus.limit = 6'd20; bus.wrap = 1;
    load_val(63);
    n_vec++; if (bus.Q_OUT !== 6'd20) begin n_err++; $display("FAIL load_clamp: got %0d want 20", bus.Q_OUT); end
    bus.limit = 6'd5; #1;
    n_vec++; if (bus.at_max !== 1'b1) begin n_err++; $display("FAIL lowered_at_max: got %b want 1", bus.at_max); end
    bus.decrease = 1; tick(); set_idle();
    n_vec++; if (bus.Q_OUT !== 6'd5 || bus.unf !== 1'b0) begin n_err++; $display("FAIL dec_to_limit: got q=%0d unf=%b want 5/0", bus.Q_OUT, bus.unf); end
    bus.increase = 1; tick(); set_idle();
    n_vec++; if (bus.Q_OUT !== 6'd0 || bus.ovf !== 1'b1) begin n_err++; $display("FAIL wrap_from_5: got q=%0d ovf=%b want 0/1", bus.Q_OUT, bus.ovf); end
  endtask

  task automatic test_simultaneous();
    bus.limit = 6'd20; bus.wrap = 1;
    load_val(7);
    bus.increase = 1; bus.decrease = 1; tick(); set_idle();
    n_vec++; if (bus.Q_OUT !== 6'd7 || bus.ovf !== 1'b0 || bus.unf !== 1'b0) begin n_err++; $display("FAIL inc_dec_hold: got q=%0d ovf=%b unf=%b want 7/0/0", bus.Q_OUT, bus.ovf, bus.unf); end
    bus.en = 0; bus.increase = 1; tick(); set_idle();
    n_vec++; if (bus.Q_OUT !== 6'd7) begin n_err++; $display("FAIL en_off_hold: got %0d want 7", bus.Q_OUT); end
    bus.parallel = 1; bus.load = 6'd12; bus.increase = 1; tick(); set_idle();
    n_vec++; if (bus.Q_OUT !== 6'd12) begin n_err++; $display("FAIL load_over_inc: got %0d want 12", bus.Q_OUT); end
  endtask

  task automatic test_back_to_back();
    // limit 0 pins the count and every wrapping step pulses
    bus.limit = 6'd0; bus.wrap = 1;
    set_idle(); bus.clr = 1; tick(); set_idle();
    bus.increase = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (bus.Q_OUT !== 6'd0 || bus.ovf !== 1'b1) begin n_err++; $display("FAIL lim0_inc[%0d]: got q=%0d ovf=%b want 0/1", i, bus.Q_OUT, bus.ovf); end
    end
    set_idle(); bus.decrease = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++; if (bus.Q_OUT !== 6'd0 || bus.unf !== 1'b1 || bus.ovf !== 1'b0) begin n_err++; $display("FAIL lim0_dec[%0d]: got q=%0d unf=%b ovf=%b want 0/1/0", i, bus.Q_OUT, bus.unf, bus.ovf); end
    end
    set_idle(); tick();
    n_vec++; if (bus.unf !== 1'b0) begin n_err++; $display("FAIL lim0_unf_stop: got %b want 0", bus.unf); end
  endtask

`ifdef COUNTER_UPDOWN_STICKY_EN
  task automatic test_sticky();
    bus.limit = 6'd9; bus.wrap = 0;
    set_idle(); bus.err_clr = 1; tick(); set_idle();
    load_val(9);
    n_vec++; if (bus.err_sticky !== 1'b0) begin n_err++; $display("FAIL sticky_clean: got %b want 0", bus.err_sticky); end
    bus.increase = 1; tick(); set_idle();
    n_vec++; if (bus.err_sticky !== 1'b1) begin n_err++; $display("FAIL sticky_set: got %b want 1", bus.err_sticky); end
    tick(); tick();
    n_vec++; if (bus.err_sticky !== 1'b1) begin n_err++; $display("FAIL sticky_hold: got %b want 1", bus.err_sticky); end
    bus.err_clr = 1; tick(); set_idle();
    n_vec++; if (bus.err_sticky !== 1'b0) begin n_err++; $display("FAIL sticky_clr: got %b want 0", bus.err_sticky); end
    bus.err_clr = 1; bus.increase = 1; tick(); set_idle();
    n_vec++; if (bus.err_sticky !== 1'b1) begin n_err++; $display("FAIL sticky_set_wins: got %b want 1", bus.err_sticky); end
  endtask
`endif

  task automatic test_random();
    logic [W-1:0] exp_val;
    set_idle(); bus.limit = 6'd30; bus.wrap = 1;
    #2 rst_n = 0; model_reset();
    #1 rst_n = 1;
    exp_q.delete();
    for (int i = 0; i < 400; i++) begin
      bus.clr      = ($urandom_range(15, 0) == 0);
      bus.parallel = ($urandom_range(7, 0) == 0);
      bus.en       = ($urandom_range(3, 0) != 0);
      bus.increase = 1'($urandom_range(1, 0));
      bus.decrease = 1'($urandom_range(1, 0));
      bus.load     = W'($urandom_range(63, 0));
      bus.wrap     = 1'($urandom_range(1, 0));
      if ($urandom_range(9, 0) == 0)
        bus.limit = ($urandom_range(3, 0) == 0) ? W'($urandom_range(2, 0)) : W'($urandom_range(63, 0));
`ifdef COUNTER_UPDOWN_STICKY_EN
      bus.err_clr  = ($urandom_range(7, 0) == 0);
`endif
      tick();
      exp_val = exp_q.pop_front();
      n_vec++; if (bus.Q_OUT !== exp_val) begin n_err++; $display("FAIL rnd_q[%0d]: got %0d want %0d", i, bus.Q_OUT, exp_val); end
      n_vec++; if (bus.ovf !== m_ovf || bus.unf !== m_unf) begin n_err++; $display("FAIL rnd_pulse[%0d]: got ovf=%b unf=%b want %b/%b", i, bus.ovf, bus.unf, m_ovf, m_unf); end
      n_vec++; if (bus.at_max !== (m_q >= int'(bus.limit)) || bus.at_min !== (m_q == 0)) begin n_err++; $display("FAIL rnd_flags[%0d]: got at_max=%b at_min=%b q_model=%0d limit=%0d", i, bus.at_max, bus.at_min, m_q, bus.limit); end
`ifdef COUNTER_UPDOWN_STICKY_EN
      n_vec++; if (bus.err_sticky !== m_err) begin n_err++; $display("FAIL rnd_sticky[%0d]: got %b want %b", i, bus.err_sticky, m_err); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_load_clamp();
    test_simultaneous();
    test_back_to_back();
`ifdef COUNTER_UPDOWN_STICKY_EN
    test_sticky();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
